// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with prescaled tick,
// load/clear, wrap/one-shot/reload modes and a run/hold/done FSM.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begin counting, or resume from HOLD / restart from DONE
//   stop       pause counting (RUN -> HOLD)
//   clear      synchronous clear to IDLE, count 0
//   load       synchronous load of load_value (clamped to limit)
//   load_value load / reload value
//   limit      terminal value counting up, reload value counting down
//   prescale   count advances every prescale+1 clocks
//   up_down    1 = up, 0 = down
//   mode       00 wrap, 01 one-shot, 10 reload, 11 as 00
//   count_out  registered count
//   running    high while in RUN
//   done       one-cycle pulse on one-shot completion
//   wrap       one-cycle pulse on wrap or reload
module param_counter #(
    parameter int WIDTH      = 10,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      count_out,
    output logic                  running,
    output logic                  done,
    output logic                  wrap
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state, state_n;
    logic [WIDTH-1:0]      count_n;
    logic [PRESCALE_W-1:0] presc, presc_n;
    logic                  done_n, wrap_n;
    logic [WIDTH-1:0]      ld_clamped;
    logic                  tick;
    logic                  terminal;

    assign ld_clamped = (load_value > limit) ? limit : load_value;

    // >= rather than == so a prescale lowered below the running
    // prescaler value still ticks right away instead of rolling over.
    assign tick = (presc >= prescale);

    assign terminal = up_down ? (count_out >= limit)
                              : (count_out == '0);

    always_comb begin
        state_n = state;
        count_n = count_out;
        presc_n = presc;
        done_n  = 1'b0;
        wrap_n  = 1'b0;

        if (clear) begin
            state_n = IDLE;
            count_n = '0;
            presc_n = '0;
        end else if (load) begin
            count_n = ld_clamped;
            presc_n = '0;
        end else if (stop) begin
            // stop outranks start everywhere; only RUN reacts to it
            if (state == RUN) begin
                state_n = HOLD;
            end
        end else if (start && state != RUN) begin
            state_n = RUN;
            unique case (state)
                IDLE: presc_n = '0;
                DONE: begin
                    presc_n = '0;
                    count_n = up_down ? '0 : limit;
                end
                default: ;
            endcase
        end else if (state == RUN) begin
            if (!tick) begin
                presc_n = presc + 1'b1;
            end else begin
                presc_n = '0;
                if (!terminal) begin
                    count_n = up_down ? count_out + 1'b1
                                      : count_out - 1'b1;
                end else begin
                    unique case (mode)
                        2'b01: begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                        2'b10: begin
                            count_n = ld_clamped;
                            wrap_n  = 1'b1;
                        end
                        default: begin
                            count_n = up_down ? '0 : limit;
                            wrap_n  = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_out <= '0;
            presc     <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_n;
            count_out <= count_n;
            presc     <= presc_n;
            running   <= (state_n == RUN);
            done      <= done_n;
            wrap      <= wrap_n;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed scoreboard bench for param_counter.
// Expected {count, running, done, wrap} queued per step, then checked.
module tb_param_counter;

    logic       clk;
    logic       reset;
    logic       start, stop, clear, load;
    logic [9:0] load_value, limit;
    logic [7:0] prescale;
    logic       up_down;
    logic [1:0] mode;
    logic [9:0] count_out;
    logic       running, done, wrap;

    int checks = 0;
    int errors = 0;

    logic [12:0] expq[$];
    string       tagq[$];

    param_counter #(.WIDTH(10), .PRESCALE_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .clear(clear),
        .load(load),
        .load_value(load_value),
        .limit(limit),
        .prescale(prescale),
        .up_down(up_down),
        .mode(mode),
        .count_out(count_out),
        .running(running),
        .done(done),
        .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [9:0] c,
                        input logic r, input logic d, input logic w);
        expq.push_back({c, r, d, w});
        tagq.push_back(tag);
    endtask

    task automatic compare();
        logic [12:0] exp_v;
        logic [12:0] got;
        string       tag;
        exp_v = expq.pop_front();
        tag   = tagq.pop_front();
        got   = {count_out, running, done, wrap};
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: got cnt=%0d run=%b done=%b wrap=%b exp cnt=%0d run=%b done=%b wrap=%b",
                   tag, got[12:3], got[2], got[1], got[0],
                   exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // one clock: queue expectation, advance, sample 1 time unit later
    task automatic step(input string tag, input logic [9:0] c,
                        input logic r, input logic d, input logic w);
        push(tag, c, r, d, w);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic now(input string tag, input logic [9:0] c,
                       input logic r, input logic d, input logic w);
        push(tag, c, r, d, w);
        compare();
    endtask

    initial begin
        reset = 1'b0;
        start = 0; stop = 0; clear = 0; load = 0;
        load_value = 0; limit = 10'd5; prescale = 0;
        up_down = 1; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        now("reset_state", 0, 0, 0, 0);
        reset = 1'b1;
        step("idle_after_reset", 0, 0, 0, 0);

        // wrap mode, up, limit 5
        start = 1;
        step("t1_start", 0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 5; i++) step("t1_up", 10'(i), 1, 0, 0);
        step("t1_wrap", 0, 1, 0, 1);
        step("t1_after_wrap", 1, 1, 0, 0);

        // one-shot, down, limit 3, prescale 2
        clear = 1;
        step("t2_clear", 0, 0, 0, 0);
        clear = 0;
        mode = 2'b01; up_down = 0; limit = 3; prescale = 2;
        load_value = 3; load = 1;
        step("t2_load", 3, 0, 0, 0);
        load = 0; start = 1;
        step("t2_start", 3, 1, 0, 0);
        start = 0;
        for (int v = 2; v >= 0; v--) begin
            step("t2_hold_a", 10'(v + 1), 1, 0, 0);
            step("t2_hold_b", 10'(v + 1), 1, 0, 0);
            step("t2_dec", 10'(v), 1, 0, 0);
        end
        step("t2_pre_a", 0, 1, 0, 0);
        step("t2_pre_b", 0, 1, 0, 0);
        step("t2_done", 0, 0, 1, 0);
        step("t2_done_held", 0, 0, 0, 0);
        start = 1;
        step("t2_restart", 3, 1, 0, 0);
        start = 0;

        // pause / resume
        clear = 1;
        step("t3_clear", 0, 0, 0, 0);
        clear = 0;
        mode = 2'b00; up_down = 1; limit = 20; prescale = 0;
        load_value = 6; load = 1;
        step("t3_load", 6, 0, 0, 0);
        load = 0; start = 1;
        step("t3_start", 6, 1, 0, 0);
        start = 0;
        step("t3_seven", 7, 1, 0, 0);
        stop = 1;
        step("t3_stop", 7, 0, 0, 0);
        stop = 0;
        for (int i = 0; i < 20; i++) step("t3_held", 7, 0, 0, 0);
        start = 1;
        step("t3_resume", 7, 1, 0, 0);
        start = 0;
        step("t3_eight", 8, 1, 0, 0);

        // simultaneous events
        load_value = 9; load = 1;
        step("t4_load_tick", 9, 1, 0, 0);
        load = 0;
        step("t4_after_load", 10, 1, 0, 0);
        clear = 1; load = 1;
        step("t4_clear_load", 0, 0, 0, 0);
        clear = 0; load = 0;
        start = 1; stop = 1;
        step("t4_start_stop", 0, 0, 0, 0);
        start = 0; stop = 0;
        step("t4_idle", 0, 0, 0, 0);

        // reload mode
        mode = 2'b10; up_down = 1; limit = 10; load_value = 4; load = 1;
        step("t5_load", 4, 0, 0, 0);
        load = 0; start = 1;
        step("t5_start", 4, 1, 0, 0);
        start = 0;
        for (int i = 5; i <= 10; i++) step("t5_up", 10'(i), 1, 0, 0);
        step("t5_reload", 4, 1, 0, 1);
        step("t5_five", 5, 1, 0, 0);
        load_value = 15;
        for (int i = 6; i <= 10; i++) step("t5_up2", 10'(i), 1, 0, 0);
        step("t5_clamp", 10, 1, 0, 1);
        step("t5_clamp_again", 10, 1, 0, 1);

        // async reset mid-run
        clear = 1;
        step("t6_clear", 0, 0, 0, 0);
        clear = 0;
        mode = 2'b00; limit = 20; prescale = 3; load_value = 6; load = 1;
        step("t6_load", 6, 0, 0, 0);
        load = 0; start = 1;
        step("t6_start", 6, 1, 0, 0);
        start = 0;
        step("t6_mid_a", 6, 1, 0, 0);
        step("t6_mid_b", 6, 1, 0, 0);
        #2;
        reset = 0;
        #1;
        now("t6_async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1;
        for (int i = 0; i < 6; i++) step("t6_idle", 0, 0, 0, 0);
        start = 1;
        step("t6_restart", 0, 1, 0, 0);
        start = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
